// File: rtl/parallel_multiplier_11_ppa_kogge_stone_pkg.sv
// Shared constants and helpers for the unsigned Kogge-Stone array multiplier.
package parallel_multiplier_11_ppa_kogge_stone_pkg;

  localparam int DEFAULT_WIDTH = 11;

  // The prefix tree needs ceil(log2(n)) levels of combine operators.
  function automatic int prefix_levels(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/parallel_multiplier_11_ppa_kogge_stone_ks_adder.sv
// Combinational N-bit Kogge-Stone adder, carry-in fixed at zero.
module ks_adder
  import parallel_multiplier_11_ppa_kogge_stone_pkg::*;
#(
  parameter int N = 22
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int LV = prefix_levels(N);

  logic [N-1:0] g [0:LV];
  logic [N-1:0] p [0:LV];

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  // Level l combines each bit with the group ending 2**l positions below it.
  generate
    for (genvar lvl = 0; lvl < LV; lvl++) begin : g_level
      localparam int DIST = 1 << lvl;
      for (genvar gi = 0; gi < N; gi++) begin : g_bit
        if (gi >= DIST) begin : g_comb
          assign g[lvl+1][gi] = g[lvl][gi] | (p[lvl][gi] & g[lvl][gi-DIST]);
          assign p[lvl+1][gi] = p[lvl][gi] & p[lvl][gi-DIST];
        end else begin : g_pass
          assign g[lvl+1][gi] = g[lvl][gi];
          assign p[lvl+1][gi] = p[lvl][gi];
        end
      end
    end
  endgenerate

  // After the last level g[LV][i] is the carry out of bits 0..i.
  assign sum  = p[0] ^ {g[LV][N-2:0], 1'b0};
  assign cout = g[LV][N-1];

  logic unused_group_p;
  assign unused_group_p = ^p[LV];

endmodule

// File: rtl/parallel_multiplier_11_ppa_kogge_stone.sv
// Unsigned width x width multiplier: AND-array partial products summed by a
// chain of Kogge-Stone adders, product registered once.
module parallel_multiplier_11_ppa_kogge_stone
  import parallel_multiplier_11_ppa_kogge_stone_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [width:1]     A,
  input  logic [width:1]     B,
  output logic [2*width:1]   S
);

  localparam int PW = 2 * width;

  logic [width-1:0] a_vec;
  logic [width-1:0] b_vec;
  logic [PW-1:0]    pp  [0:width-1];
  logic [PW-1:0]    acc [0:width-1];
  logic [width-2:0] unused_cout;
  logic [PW-1:0]    s_reg;

  // Re-base the 1-based ports to 0-based vectors; numeric value is unchanged.
  assign a_vec = A;
  assign b_vec = B;

  generate
    for (genvar gi = 0; gi < width; gi++) begin : g_pp
      assign pp[gi] = {{width{1'b0}}, a_vec & {width{b_vec[gi]}}} << gi;
    end
  endgenerate

  assign acc[0] = pp[0];

  generate
    for (genvar gi = 1; gi < width; gi++) begin : g_acc
      ks_adder #(.N(PW)) u_ks (
        .a    (acc[gi-1]),
        .b    (pp[gi]),
        .sum  (acc[gi]),
        .cout (unused_cout[gi-1])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg <= '0;
    end else begin
      s_reg <= acc[width-1];
    end
  end

  assign S = s_reg;

endmodule

// File: tb/tb_parallel_multiplier_11_ppa_kogge_stone.sv
// Directed and random checks of the registered unsigned multiplier.
module tb_parallel_multiplier_11_ppa_kogge_stone;

  localparam int W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [W:1]        A;
  logic [2*W:1]      S;
  logic [W:1]        B;

  int tests  = 0;
  int failed = 0;

  logic [2*W-1:0] exp_q [$];

  parallel_multiplier_11_ppa_kogge_stone #(.width(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .S     (S)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned prod;
    prod = longint'(a) * longint'(b);
    return prod[2*W-1:0];
  endfunction

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("[TB] %s A=%0d B=%0d S=%0d expected=%0d", tag, A, B, obs, exp);
  endtask

  task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp);
    A = a;
    B = b;
    @(posedge clk);
    #1;
    check(tag, S, exp);
  endtask

  initial begin
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] e;

    rst_n = 1'b0;
    A = 11'd2047;
    B = 11'd2047;
    #1;
    check("reset_initial", S, 22'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", S, 22'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", S, 22'h3FF001);

    // Asynchronous clear mid-cycle, well before the next rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", S, 22'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("zero_a",     11'd0,    11'd1234, 22'd0);
    apply("identity",   11'd1,    11'd1234, 22'd1234);
    apply("max",        11'd2047, 11'd2047, 22'd4190209);
    apply("pow2_sq",    11'd1024, 11'd1024, 22'd1048576);
    apply("pow2_by1",   11'd1024, 11'd1,    22'd1024);
    apply("alt_bits",   11'd1365, 11'd682,  22'd930930);
    apply("zero_b",     11'd2047, 11'd0,    22'd0);

    // Back-to-back random operands, each product checked one cycle later.
    for (int i = 0; i < 50; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      A = ra;
      B = rb;
      exp_q.push_back(model(ra, rb));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("random_%0d", i), S, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
